fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned word into an IF/ID register that feeds the decoder through a valid/ready handshake.
- Resolves J/JAL targets locally so jumps cost zero bubbles. Accepts redirects for branches resolved downstream.
- Blocks fetches beyond the populated memory range and counts accepted fetches.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_next_pc.sv | 28 ++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by fetch, decode and control.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_jump(input logic [31:0] instr);
    logic [5:0] opcode;
    opcode = instr[OPCODE_MSB:OPCODE_LSB];
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: downstream redirect, then J/JAL target, then pc+4.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [25:0] jump_index;

  assign pc_plus4   = pc + 32'd4;
  assign jump_index = imem_instr[TARGET_MSB:TARGET_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (redirect_valid) begin
      // Fetch is always word aligned; drop whatever low bits the redirect carries.
      next_pc = redirect_target & ~32'h0000_0003;
    end else if (is_jump(imem_instr)) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, resolves jumps locally.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MaxPc = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;
  logic        fault_q;
  logic [31:0] count_q;

  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        in_range;
  logic        load;

  fetch_next_pc u_next_pc (
    .pc              (pc_q),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .pc_plus4        (pc_plus4)
  );

  assign in_range = (pc_q <= MaxPc);
  assign load     = in_range & ~fault_q & (~id_valid_q | id_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      fault_q       <= 1'b0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any decoder accept; the in-flight fetch is discarded.
      pc_q       <= next_pc;
      id_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (load) begin
      id_instr_q    <= imem_instr;
      id_pc_q       <= pc_q;
      id_pc_plus4_q <= pc_plus4;
      id_valid_q    <= 1'b1;
      pc_q          <= next_pc;
      count_q       <= count_q + 32'd1;
    end else begin
      if (id_ready) begin
        id_valid_q <= 1'b0;
      end
      if (!in_range) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table, accept scoreboard, reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (1024)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_idpc;
    logic        exp_fault;
    logic [31:0] exp_count;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic ready, input logic rv, input logic [31:0] rt,
                     input logic [31:0] addr, input logic valid, input logic [31:0] instr,
                     input logic [31:0] idpc, input logic fault, input logic [31:0] count);
    vec_t v;
    v.ready = ready; v.rv = rv; v.rt = rt; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_instr = instr; v.exp_idpc = idpc; v.exp_fault = fault; v.exp_count = count;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        prev_valid;
    logic [31:0] prev_instr;
    logic [31:0] prev_idpc;
    sb_t         got;

    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + 32'(i);
    mem[0]  = 32'h8E68_0000;
    mem[1]  = 32'h8E69_0004;
    mem[2]  = 32'h0109_8020;
    mem[4]  = 32'h0800_0019;
    mem[25] = 32'h0109_8022;

    //  rdy rv  target        addr          vld instr         id_pc         flt count
    add(1, 0, 32'h0,        32'h0000_0004, 1, 32'h8E68_0000, 32'h0000_0000, 0, 1);
    add(1, 0, 32'h0,        32'h0000_0008, 1, 32'h8E69_0004, 32'h0000_0004, 0, 2);
    add(1, 0, 32'h0,        32'h0000_000C, 1, 32'h0109_8020, 32'h0000_0008, 0, 3);
    add(1, 0, 32'h0,        32'h0000_0010, 1, 32'h2000_0003, 32'h0000_000C, 0, 4);
    add(1, 0, 32'h0,        32'h0000_0064, 1, 32'h0800_0019, 32'h0000_0010, 0, 5);
    add(1, 0, 32'h0,        32'h0000_0068, 1, 32'h0109_8022, 32'h0000_0064, 0, 6);
    add(0, 0, 32'h0,        32'h0000_0068, 1, 32'h0109_8022, 32'h0000_0064, 0, 6);
    add(0, 0, 32'h0,        32'h0000_0068, 1, 32'h0109_8022, 32'h0000_0064, 0, 6);
    add(0, 0, 32'h0,        32'h0000_0068, 1, 32'h0109_8022, 32'h0000_0064, 0, 6);
    add(1, 0, 32'h0,        32'h0000_006C, 1, 32'h2000_001A, 32'h0000_0068, 0, 7);
    add(1, 1, 32'h4,        32'h0000_0004, 0, 32'h2000_001A, 32'h0000_0068, 0, 7);
    add(1, 0, 32'h0,        32'h0000_0008, 1, 32'h8E69_0004, 32'h0000_0004, 0, 8);
    add(1, 1, 32'h66,       32'h0000_0064, 0, 32'h8E69_0004, 32'h0000_0004, 0, 8);
    add(1, 0, 32'h0,        32'h0000_0068, 1, 32'h0109_8022, 32'h0000_0064, 0, 9);
    add(0, 1, 32'h3FC,      32'h0000_03FC, 0, 32'h0109_8022, 32'h0000_0064, 0, 9);
    add(0, 0, 32'h0,        32'h0000_0400, 1, 32'h2000_00FF, 32'h0000_03FC, 0, 10);
    add(0, 0, 32'h0,        32'h0000_0400, 1, 32'h2000_00FF, 32'h0000_03FC, 1, 10);
    add(1, 0, 32'h0,        32'h0000_0400, 0, 32'h2000_00FF, 32'h0000_03FC, 1, 10);
    add(1, 0, 32'h0,        32'h0000_0400, 0, 32'h2000_00FF, 32'h0000_03FC, 1, 10);
    add(1, 1, 32'h400,      32'h0000_0400, 0, 32'h2000_00FF, 32'h0000_03FC, 0, 10);
    add(1, 0, 32'h0,        32'h0000_0400, 0, 32'h2000_00FF, 32'h0000_03FC, 1, 10);
    add(1, 1, 32'h0,        32'h0000_0000, 0, 32'h2000_00FF, 32'h0000_03FC, 0, 10);
    add(1, 0, 32'h0,        32'h0000_0004, 1, 32'h8E68_0000, 32'h0000_0000, 0, 11);
    add(0, 1, 32'h10,       32'h0000_0010, 0, 32'h8E68_0000, 32'h0000_0000, 0, 11);
    add(0, 1, 32'h23,       32'h0000_0020, 0, 32'h8E68_0000, 32'h0000_0000, 0, 11);
    add(1, 0, 32'h0,        32'h0000_0024, 1, 32'h2000_0008, 32'h0000_0020, 0, 12);

    rst_n = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset id_valid", {31'b0, id_valid}, 32'h0);
    check("reset id_instr", id_instr, 32'h0);
    check("reset id_pc", id_pc, 32'h0);
    check("reset id_pc_plus4", id_pc_plus4, 32'h0);
    check("reset fetch_fault", {31'b0, fetch_fault}, 32'h0);
    check("reset fetch_count", fetch_count, 32'h0);

    prev_valid = 1'b0;
    prev_instr = '0;
    prev_idpc  = '0;
    foreach (vecs[k]) begin
      id_ready        = vecs[k].ready;
      redirect_valid  = vecs[k].rv;
      redirect_target = vecs[k].rt;
      // The decoder accepts the current entry this cycle if it is valid and ready is high.
      if (prev_valid && vecs[k].ready) begin
        got.instr = prev_instr;
        got.pc    = prev_idpc;
        sb.push_back(got);
      end
      #1;
      if (id_valid && id_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL sb underflow: accept of 0x%08h@0x%08h with nothing expected",
                   id_instr, id_pc);
        end else begin
          got = sb.pop_front();
          if (id_instr === got.instr && id_pc === got.pc) passed++;
          else $display("FAIL sb accept: got 0x%08h@0x%08h expected 0x%08h@0x%08h",
                        id_instr, id_pc, got.instr, got.pc);
        end
      end
      @(negedge clk);
      #1;
      check($sformatf("v%0d imem_addr", k), imem_addr, vecs[k].exp_addr);
      check($sformatf("v%0d id_valid", k), {31'b0, id_valid}, {31'b0, vecs[k].exp_valid});
      check($sformatf("v%0d id_instr", k), id_instr, vecs[k].exp_instr);
      check($sformatf("v%0d id_pc", k), id_pc, vecs[k].exp_idpc);
      check($sformatf("v%0d id_pc_plus4", k), id_pc_plus4, vecs[k].exp_idpc + 32'd4);
      check($sformatf("v%0d fetch_fault", k), {31'b0, fetch_fault}, {31'b0, vecs[k].exp_fault});
      check($sformatf("v%0d fetch_count", k), fetch_count, vecs[k].exp_count);
      prev_valid = vecs[k].exp_valid;
      prev_instr = vecs[k].exp_instr;
      prev_idpc  = vecs[k].exp_idpc;
    end
    check("sb drained", 32'(sb.size()), 32'h0);

    // Async reset between edges while IF/ID holds a valid entry.
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async imem_addr", imem_addr, 32'h0);
    check("async id_valid", {31'b0, id_valid}, 32'h0);
    check("async id_instr", id_instr, 32'h0);
    check("async id_pc", id_pc, 32'h0);
    check("async id_pc_plus4", id_pc_plus4, 32'h0);
    check("async fetch_count", fetch_count, 32'h0);
    @(negedge clk);
    check("held reset id_valid", {31'b0, id_valid}, 32'h0);
    check("held reset imem_addr", imem_addr, 32'h0);
    id_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset imem_addr", imem_addr, 32'h4);
    check("post-reset id_valid", {31'b0, id_valid}, 32'h1);
    check("post-reset id_instr", id_instr, 32'h8E68_0000);
    check("post-reset id_pc", id_pc, 32'h0);
    check("post-reset fetch_count", fetch_count, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
